// File: rtl/nibble_serial_adder_pkg.sv
// Shared types and constants for the nibble-serial adder.
// Holds the FSM state encoding, the slice width and the nibble-counter width helper.
package nibble_serial_adder_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } adderState_t;

  // Smallest counter width able to index n nibbles; never narrower than one bit.
  function automatic int cntWidth(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/nibble_serial_adder_if.sv
// Operand/result handshake bundle between a source/sink and the nibble-serial adder.
// The slave modport is the adder's view; master is the producer/consumer side.
interface nibble_serial_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;

  modport slave (
    input  in_valid, in_a, in_b, in_cin, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf
  );

  modport master (
    output in_valid, in_a, in_b, in_cin, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf
  );
endinterface

// File: rtl/nibble_serial_adder_add4_slice.sv
// Combinational 4-bit ripple-carry add slice shared by every nibble of the serial adder.
module add4_slice
  import nibble_serial_adder_pkg::*;
(
  input  logic [NIBBLE_W-1:0] i_a,
  input  logic [NIBBLE_W-1:0] i_b,
  input  logic                i_cin,
  output logic [NIBBLE_W-1:0] o_sum,
  output logic                o_cout
);

  logic w_carry;

  always_comb begin
    o_sum   = '0;
    w_carry = i_cin;
    for (int k = 0; k < NIBBLE_W; k++) begin
      o_sum[k] = i_a[k] ^ i_b[k] ^ w_carry;
      w_carry  = (i_a[k] & i_b[k]) | (w_carry & (i_a[k] ^ i_b[k]));
    end
    o_cout = w_carry;
  end

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder: one nibble per clock through a single 4-bit slice,
// LSB first, with the carry held in a register between nibbles.
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter  int WIDTH   = 16,
  localparam int NIBBLES = WIDTH / NIBBLE_W
) (
  input  logic                   clk,
  input  logic                   rst,
  nibble_serial_adder_if.slave   bus,
  output logic                   busy
);

  localparam int              CNT_W    = cntWidth(NIBBLES);
  localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(NIBBLES - 1);

  adderState_t         r_state;
  adderState_t         w_nextState;
  logic [WIDTH-1:0]    r_aSh;
  logic [WIDTH-1:0]    r_bSh;
  logic                r_carry;
  logic [CNT_W-1:0]    r_nibCnt;
  logic [WIDTH-1:0]    r_outSum;
  logic                r_outCout;
  logic                r_outOvf;
  logic [NIBBLE_W-1:0] w_sliceSum;
  logic                w_sliceCout;
  logic [WIDTH-1:0]    w_sumNext;
  logic                w_accept;
  logic                w_lastNib;
  logic                w_inReady;
  logic                w_outValid;
  logic                w_busy;

  assign w_accept  = (r_state == IDLE) && bus.in_valid;
  assign w_lastNib = (r_state == ADD) && (r_nibCnt == LAST_NIB);

  add4_slice u_slice (
    .i_a    (r_aSh[NIBBLE_W-1:0]),
    .i_b    (r_bSh[NIBBLE_W-1:0]),
    .i_cin  (r_carry),
    .o_sum  (w_sliceSum),
    .o_cout (w_sliceCout)
  );

  // Partial sums enter from the MSB end so the word is LSB-aligned after the last nibble.
  if (NIBBLES == 1) begin : gSingle
    assign w_sumNext = w_sliceSum;
  end else begin : gAcc
    logic [WIDTH-NIBBLE_W-1:0] r_sumAcc;

    always_ff @(posedge clk or posedge rst) begin
      if (rst)                 r_sumAcc <= '0;
      else if (r_state == ADD) r_sumAcc <= w_sumNext[WIDTH-1:NIBBLE_W];
    end

    assign w_sumNext = {w_sliceSum, r_sumAcc};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      IDLE:    if (w_accept)      w_nextState = ADD;
      ADD:     if (w_lastNib)     w_nextState = DONE;
      DONE:    if (bus.out_ready) w_nextState = IDLE;
      default:                    w_nextState = IDLE;
    endcase
  end

  always_comb begin
    w_inReady  = 1'b0;
    w_outValid = 1'b0;
    w_busy     = 1'b0;
    unique case (r_state)
      IDLE:    w_inReady = 1'b1;
      ADD:     w_busy    = 1'b1;
      DONE: begin
        w_outValid = 1'b1;
        w_busy     = 1'b1;
      end
      default: w_inReady = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_aSh    <= '0;
      r_bSh    <= '0;
      r_carry  <= 1'b0;
      r_nibCnt <= '0;
    end else if (w_accept) begin
      r_aSh    <= bus.in_a;
      r_bSh    <= bus.in_b;
      r_carry  <= bus.in_cin;
      r_nibCnt <= '0;
    end else if (r_state == ADD) begin
      r_aSh    <= r_aSh >> NIBBLE_W;
      r_bSh    <= r_bSh >> NIBBLE_W;
      r_carry  <= w_sliceCout;
      r_nibCnt <= r_nibCnt + 1'b1;
    end
  end

  // Result registers only change on the final nibble, so they hold through handoff.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_outSum  <= '0;
      r_outCout <= 1'b0;
      r_outOvf  <= 1'b0;
    end else if (w_lastNib) begin
      r_outSum  <= w_sumNext;
      r_outCout <= w_sliceCout;
      r_outOvf  <= r_aSh[NIBBLE_W-1] ^ r_bSh[NIBBLE_W-1]
                 ^ w_sliceSum[NIBBLE_W-1] ^ w_sliceCout;
    end
  end

  assign bus.in_ready  = w_inReady;
  assign bus.out_valid = w_outValid;
  assign bus.out_sum   = r_outSum;
  assign bus.out_cout  = r_outCout;
  assign bus.out_ovf   = r_outOvf;
  assign busy          = w_busy;

endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
- Multi-cycle wide adder built around a single 4-bit add slice.
- Accepts WIDTH-bit operands and a carry-in on a valid/ready handshake.
- Adds one nibble per clock, LSB first, through a registered carry, then presents sum, carry-out and signed overflow on a valid/ready output.
- Sits directly upstream of the 4-bit adder: it sequences operand nibbles into the slice and consumes the slice's sum/carry.

Parameters:
- WIDTH, 16, operand/sum width in bits; must be a multiple of 4 and >= 4.
- NIBBLES, WIDTH/4, derived; number of ADD cycles; not to be overridden.

Ports:
- clk  input  1  single clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands present.
- in_ready  output  1  block can accept operands.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_cin  input  1  carry-in.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes result.
- out_sum  output  WIDTH  registered sum.
- out_cout  output  1  carry out of bit WIDTH-1.
- out_ovf  output  1  two's-complement overflow.
- busy  output  1  high in ADD or DONE.

Behaviour:
- Reset: async on rst high. State = IDLE; in_ready=1; out_valid=0; busy=0; out_sum=0; out_cout=0; out_ovf=0; all internal registers cleared.
- Reset mid-operation: any in-flight operation is discarded with no output.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready at edge T: capture in_a and in_b into shift registers, carry_reg=in_cin, nib_cnt=0, go to ADD.
- ADD:
  - in_ready=0, busy=1.
  - Each edge: slice computes a_sh[3:0] + b_sh[3:0] + carry_reg.
  - The 4-bit slice sum shifts into the sum register from the MSB end.
  - carry_reg is updated; a_sh and b_sh shift right by 4; nib_cnt increments.
  - On the edge processing nibble NIBBLES-1, go to DONE and register:
    - out_cout = final slice carry.
    - out_ovf = a[WIDTH-1] ^ b[WIDTH-1] ^ sum[WIDTH-1] ^ cout. Operand MSBs are held from the captured final nibble.
- DONE:
  - out_valid=1, in_ready=0.
  - out_sum, out_cout and out_ovf stay stable until out_valid&out_ready.
  - On that handshake, go to IDLE at the same edge.
- Latency:
  - out_valid rises exactly NIBBLES cycles after the accepting edge (4 for WIDTH=16).
  - Minimum issue interval is NIBBLES+2 cycles when out_ready is held high.
- Busy input: in_valid while busy is ignored; the source must hold its operands (standard valid/ready).
- After handoff: out_sum, out_cout and out_ovf retain their last values until the next result is registered. They are only meaningful while out_valid=1.
- Arithmetic: modulo 2^WIDTH; no sign extension; the carry chain across nibbles is exact, so the result equals in_a+in_b+in_cin.
- out_ready while out_valid=0 has no effect.
- No simultaneous accept/complete path: in_ready is low in DONE.

Decomposition:
- Shared package:
  - State enum IDLE/ADD/DONE (2-bit encoding).
  - NIBBLE_W=4 constant.
  - Counter-width function clog2(NIBBLES), minimum 1 bit.
- One sub-module, add4_slice: purely combinational 4-bit ripple add with carry-in, 4-bit sum and carry-out. It is instantiated once.
- The FSM, shift registers and output registers live in the top.

Test Plan:
- Basic add: WIDTH=16, in_a=0x1234, in_b=0x4321, cin=0 → out_sum=0x5555, cout=0, ovf=0. out_valid is asserted 4 cycles after accept.
- Full carry ripple: in_a=0xFFFF, in_b=0x0001, cin=0 → out_sum=0x0000, cout=1, ovf=0. Also in_a=0xFFFF, in_b=0x0000, cin=1 → sum=0x0000, cout=1.
- Signed overflow: 0x7FFF+0x0001 → sum=0x8000, ovf=1, cout=0. 0x8000+0x8000 → sum=0x0000, ovf=1, cout=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE and toggle in_valid with new operands.
  - Required: outputs stable, in_ready=0, and the new operands are not captured.
  - Raise out_ready: return to IDLE, then accept next.
- Reset mid-ADD: assert rst after 2 nibbles.
  - Required: out_valid=0, in_ready=1, busy=0 immediately (async).
  - Next operation 0x0F0F+0x0101 → 0x1010 correct.
- Parameter corner: WIDTH=4, in_a=0xF, in_b=0xF, cin=1 → sum=0xF, cout=1, ovf=0, out_valid 1 cycle after accept.
